bus_ram_slave: RTL and testbench
================================

BUS_RAM_SLAVE -- requirements
Module: bus_ram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h5000_0000, byte address of word 0.
REQ-002 SHALL have parameter ADDR_BITS, default 10, log2 of word depth (1024 x 32-bit words).
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, access wait states before data phase.
REQ-004 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port beginTransactionIn  input  1  initiator starts transaction, address phase.
REQ-007 SHALL have port addressDataIn  input  32  address in address phase, write data in data phase.
REQ-008 SHALL have port byteEnablesIn  input  4  byte lane enables, sampled in address phase.
REQ-009 SHALL have port burstSizeIn  input  8  burst length minus one, sampled in address phase.
REQ-010 SHALL have port readNotWriteIn  input  1  1 = read, 0 = write, sampled in address phase.
REQ-011 SHALL have port dataValidIn  input  1  write data valid.
REQ-012 SHALL have port endTransactionIn  input  1  initiator ends write transaction.
REQ-013 SHALL have port busErrorIn  input  1  bus error from another agent.
REQ-014 SHALL have port addressDataOut  output  32  read data; 0 when not driving.
REQ-015 SHALL have port dataValidOut  output  1  read data valid.
REQ-016 SHALL have port busyOut  output  1  stall; initiator holds write data while high.
REQ-017 SHALL have port endTransactionOut  output  1  slave ends read or error transaction.
REQ-018 SHALL have port busErrorOut  output  1  transaction rejected.

Function
REQ-019 SHALL implement states IDLE, WAIT, WRITE, READ, END, ERROR; all outputs registered and 0 outside their asserting state (wired-OR bus).
REQ-020 SHALL in IDLE ignore beginTransactionIn unless BASE_ADDRESS <= address < BASE_ADDRESS + 4*2^ADDR_BITS (selected).
REQ-021 SHALL on selected begin latch word pointer = address[ADDR_BITS+1:2], remaining = burstSizeIn, direction, byte enables.
REQ-022 SHALL go to ERROR if address[1:0] != 0, or pointer + burstSizeIn > 2^ADDR_BITS - 1 (no wrap), or burstSizeIn != 0 with byteEnablesIn != 4'hF.
REQ-023 SHALL in ERROR assert busErrorOut and endTransactionOut together for exactly one cycle, then IDLE; memory unchanged.
REQ-024 SHALL otherwise enter WAIT, asserting busyOut for WAIT_CYCLES cycles (skip WAIT when 0), then WRITE or READ.
REQ-025 SHALL in WAIT ignore dataValidIn (no write).
REQ-026 SHALL in WRITE, each cycle with dataValidIn=1, write addressDataIn to mem[pointer] under byte enables, increment pointer, decrement remaining.
REQ-027 SHALL ignore dataValidIn words beyond burstSizeIn+1 (no write, pointer held).
REQ-028 SHALL leave WRITE to IDLE on endTransactionIn; data valid in the same cycle is written first; short bursts legal.
REQ-029 SHALL in READ assert dataValidOut with addressDataOut = mem[pointer] on burstSizeIn+1 consecutive cycles, first word the cycle after WAIT ends, no gaps.
REQ-030 SHALL after the last read word assert endTransactionOut one cycle (END), then IDLE.
REQ-031 SHALL accept a new beginTransactionIn in the cycle after returning to IDLE.
REQ-032 SHALL on busErrorIn=1 in any non-IDLE state abort to IDLE next cycle, outputs 0, no further writes, no endTransactionOut.
REQ-033 SHALL ignore beginTransactionIn in non-IDLE states.

Reset
REQ-034 SHALL on reset low, asynchronously, enter IDLE and drive all outputs 0, pointer and counters 0.
REQ-035 SHALL leave memory contents untouched by reset; reset mid-burst discards the remainder.
REQ-036 SHALL resume operation on the first rising clock edge after reset deasserts.

Verification
REQ-037 Write burst: begin addr 0x5000_0010, burst 3, write, data 0xA0..0xA3 -> busyOut high 2 cycles, words 4..7 = 0xA0..0xA3.
REQ-038 Read burst: begin addr 0x5000_0010, burst 3, read -> 2 wait cycles, dataValidOut 4 consecutive cycles 0xA0..0xA3, endTransactionOut next cycle, then all outputs 0.
REQ-039 Byte write: single write 0x5000_0000, byteEnables 4'b0010, data 0x1234_5678 over 0xFFFF_FFFF -> readback 0xFFFF_56FF.
REQ-040 Errors: addr 0x5000_0FFC burst 1; addr 0x5000_0002 -> busErrorOut+endTransactionOut one cycle each, memory unchanged; addr 0x4000_0000 -> no response.
REQ-041 Abort: busErrorIn pulse during read word 2 of 8 -> dataValidOut low next cycle, no endTransactionOut; next transaction serviced normally.
REQ-042 Reset mid-write after 2 of 4 words -> outputs 0 immediately, words 0-1 written, words 2-3 unchanged.

Source files
------------

// File: rtl/bus_ram_slave.sv
// Bus-attached 32-bit RAM slave with wait states, byte-lane writes, bursts and
// error/abort handling. All bus outputs are registered and idle low for wired-OR.
module bus_ram_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int          ADDR_BITS    = 10,
  parameter int          WAIT_CYCLES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        beginTransactionIn,
  input  logic [31:0] addressDataIn,
  input  logic [3:0]  byteEnablesIn,
  input  logic [7:0]  burstSizeIn,
  input  logic        readNotWriteIn,
  input  logic        dataValidIn,
  input  logic        endTransactionIn,
  input  logic        busErrorIn,
  output logic [31:0] addressDataOut,
  output logic        dataValidOut,
  output logic        busyOut,
  output logic        endTransactionOut,
  output logic        busErrorOut
);

  localparam int              DEPTH   = 1 << ADDR_BITS;
  localparam logic [32:0]     LIMIT   = {1'b0, BASE_ADDRESS} + (33'(DEPTH) << 2);
  localparam int              SUMW    = ADDR_BITS + 9;
  localparam logic [SUMW-1:0] MAX_PTR = SUMW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_WRITE, S_READ, S_END, S_ERROR
  } state_t;

  state_t               state_q;
  logic [ADDR_BITS-1:0] ptr_q;
  logic [7:0]           rem_q;
  logic                 rnw_q;
  logic [3:0]           be_q;
  logic                 full_q;
  logic [3:0]           wcnt_q;
  logic [31:0]          dout_q;
  logic                 dv_q;
  logic                 busy_q;
  logic                 eto_q;
  logic                 berr_q;

  logic [31:0]          mem [DEPTH];

  logic                 req_sel;
  logic                 req_err;
  logic [ADDR_BITS-1:0] start_ptr;
  logic [SUMW-1:0]      end_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [31:0]          rd_word;
  logic                 wr_en;

  assign start_ptr = addressDataIn[ADDR_BITS+1:2];
  assign end_ptr   = SUMW'(start_ptr) + SUMW'(burstSizeIn);
  assign req_sel   = (addressDataIn >= BASE_ADDRESS) && ({1'b0, addressDataIn} < LIMIT);
  // Bursts must be full-word, aligned, and must not run past the last word.
  assign req_err   = (addressDataIn[1:0] != 2'b00) || (end_ptr > MAX_PTR) ||
                     ((burstSizeIn != 8'd0) && (byteEnablesIn != 4'hF));

  // With no wait states the first read word is fetched straight from the request.
  assign rd_ptr  = (state_q == S_IDLE) ? start_ptr : ptr_q;
  assign rd_word = mem[rd_ptr];

  // An abort on busErrorIn suppresses any write presented in the same cycle.
  assign wr_en = (state_q == S_WRITE) && dataValidIn && !full_q && !busErrorIn;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[ptr_q][8*b +: 8] <= addressDataIn[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      rnw_q   <= 1'b0;
      be_q    <= '0;
      full_q  <= 1'b0;
      wcnt_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      eto_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      dout_q <= '0;
      dv_q   <= 1'b0;
      busy_q <= 1'b0;
      eto_q  <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (beginTransactionIn && req_sel) begin
            ptr_q  <= start_ptr;
            rem_q  <= burstSizeIn;
            rnw_q  <= readNotWriteIn;
            be_q   <= byteEnablesIn;
            full_q <= 1'b0;
            if (req_err) begin
              state_q <= S_ERROR;
              berr_q  <= 1'b1;
              eto_q   <= 1'b1;
            end else if (WAIT_CYCLES != 0) begin
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
              wcnt_q  <= 4'(WAIT_CYCLES - 1);
            end else if (readNotWriteIn) begin
              state_q <= S_READ;
              dv_q    <= 1'b1;
              dout_q  <= rd_word;
              ptr_q   <= start_ptr + ADDR_BITS'(1);
            end else begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WAIT: begin
          if (busErrorIn) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == 4'd0) begin
            if (rnw_q) begin
              state_q <= S_READ;
              dv_q    <= 1'b1;
              dout_q  <= rd_word;
              ptr_q   <= ptr_q + ADDR_BITS'(1);
            end else begin
              state_q <= S_WRITE;
            end
          end else begin
            busy_q <= 1'b1;
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        S_WRITE: begin
          if (busErrorIn) begin
            state_q <= S_IDLE;
          end else begin
            if (wr_en) begin
              ptr_q <= ptr_q + ADDR_BITS'(1);
              if (rem_q == 8'd0) full_q <= 1'b1;
              else               rem_q  <= rem_q - 8'd1;
            end
            if (endTransactionIn) state_q <= S_IDLE;
          end
        end
        S_READ: begin
          if (busErrorIn) begin
            state_q <= S_IDLE;
          end else if (rem_q == 8'd0) begin
            state_q <= S_END;
            eto_q   <= 1'b1;
          end else begin
            dv_q   <= 1'b1;
            dout_q <= rd_word;
            ptr_q  <= ptr_q + ADDR_BITS'(1);
            rem_q  <= rem_q - 8'd1;
          end
        end
        S_END:   state_q <= S_IDLE;
        S_ERROR: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign addressDataOut    = dout_q;
  assign dataValidOut      = dv_q;
  assign busyOut           = busy_q;
  assign endTransactionOut = eto_q;
  assign busErrorOut       = berr_q;

endmodule

// File: tb/tb_bus_ram_slave.sv
// Directed bench for bus_ram_slave: bursts, byte lanes, errors, abort and reset.
module tb_bus_ram_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        beginTransactionIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        readNotWriteIn;
  logic        dataValidIn;
  logic        endTransactionIn;
  logic        busErrorIn;
  logic [31:0] addressDataOut;
  logic        dataValidOut;
  logic        busyOut;
  logic        endTransactionOut;
  logic        busErrorOut;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_mem [1024];
  logic [31:0] last_rd0;

  bus_ram_slave dut (
    .clock(clock), .reset(reset),
    .beginTransactionIn(beginTransactionIn), .addressDataIn(addressDataIn),
    .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn),
    .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn),
    .endTransactionIn(endTransactionIn), .busErrorIn(busErrorIn),
    .addressDataOut(addressDataOut), .dataValidOut(dataValidOut),
    .busyOut(busyOut), .endTransactionOut(endTransactionOut),
    .busErrorOut(busErrorOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl_bits();
    return {28'd0, busyOut, dataValidOut, endTransactionOut, busErrorOut};
  endfunction

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic start_txn(input logic [31:0] addr, input logic [3:0] be,
                           input logic [7:0] burst, input logic rnw);
    step();
    beginTransactionIn = 1'b1; addressDataIn = addr; byteEnablesIn = be;
    burstSizeIn = burst; readNotWriteIn = rnw;
    step();
    beginTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
    burstSizeIn = '0; readNotWriteIn = 1'b0;
  endtask

  task automatic write_words(input logic [31:0] addr, input logic [3:0] be, input int burst,
                             input int ndrive, input logic [31:0] d0, input bit chk_wait);
    int busy_n = 0;
    int base   = int'(addr[11:2]);
    start_txn(addr, be, 8'(burst), 1'b0);
    while (busyOut && busy_n < 20) begin
      busy_n++;
      dataValidIn = 1'b1; addressDataIn = 32'hDEAD_BEEF;
      step();
    end
    if (chk_wait) check("write_busy_cycles", 32'(busy_n), 32'd2);
    for (int i = 0; i < ndrive; i++) begin
      dataValidIn = 1'b1; addressDataIn = d0 + 32'(i);
      endTransactionIn = (i == ndrive - 1);
      step();
    end
    dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = '0;
    for (int i = 0; i <= burst && i < ndrive; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) exp_mem[base+i][8*b +: 8] = (d0 + 32'(i)) >> (8*b);
      end
    end
  endtask

  task automatic read_words(input logic [31:0] addr, input int burst, input bit chk_wait);
    int gap  = 0;
    int base = int'(addr[11:2]);
    start_txn(addr, 4'hF, 8'(burst), 1'b1);
    while (!dataValidOut && gap < 20) begin
      gap++;
      step();
    end
    if (chk_wait) check("read_wait_cycles", 32'(gap), 32'd2);
    last_rd0 = addressDataOut;
    for (int i = 0; i <= burst; i++) begin
      check("rd_valid", {31'd0, dataValidOut}, 32'd1);
      check("rd_data", addressDataOut, exp_mem[base+i]);
      step();
    end
    check("rd_end_ctl", ctl_bits(), 32'h2);
    check("rd_end_data", addressDataOut, 32'd0);
    step();
    check("rd_idle_ctl", ctl_bits(), 32'd0);
  endtask

  task automatic error_txn(input string tag, input logic [31:0] addr, input logic [3:0] be,
                           input logic [7:0] burst);
    start_txn(addr, be, burst, 1'b0);
    check({tag, "_resp"}, ctl_bits(), 32'h3);
    dataValidIn = 1'b1; addressDataIn = 32'h0BAD_0BAD; endTransactionIn = 1'b1;
    step();
    check({tag, "_clear"}, ctl_bits(), 32'd0);
    dataValidIn = 1'b0; addressDataIn = '0; endTransactionIn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b0; beginTransactionIn = 1'b0; addressDataIn = '0; byteEnablesIn = '0;
    burstSizeIn = '0; readNotWriteIn = 1'b0; dataValidIn = 1'b0;
    endTransactionIn = 1'b0; busErrorIn = 1'b0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
    #12;
    check("reset_ctl", ctl_bits(), 32'd0);
    check("reset_data", addressDataOut, 32'd0);
    step();
    reset = 1'b1;

    // Write and read back a 4-word burst at words 4..7.
    write_words(32'h5000_0010, 4'hF, 3, 4, 32'hA0, 1'b1);
    read_words(32'h5000_0010, 3, 1'b1);
    check("burst_word4", last_rd0, 32'hA0);

    // Byte-lane write over all-ones.
    write_words(32'h5000_0000, 4'hF, 0, 1, 32'hFFFF_FFFF, 1'b0);
    write_words(32'h5000_0000, 4'b0010, 0, 1, 32'h1234_5678, 1'b0);
    read_words(32'h5000_0000, 0, 1'b0);
    check("byte_write", last_rd0, 32'hFFFF_56FF);

    // Rejected and unselected requests.
    write_words(32'h5000_0FFC, 4'hF, 0, 1, 32'h3333_3333, 1'b0);
    error_txn("err_overrun", 32'h5000_0FFC, 4'hF, 8'd1);
    error_txn("err_misalign", 32'h5000_0002, 4'hF, 8'd0);
    error_txn("err_be_burst", 32'h5000_0000, 4'h3, 8'd1);
    read_words(32'h5000_0FFC, 0, 1'b0);
    check("err_word1023", last_rd0, 32'h3333_3333);
    read_words(32'h5000_0000, 0, 1'b0);
    check("err_word0", last_rd0, 32'hFFFF_56FF);
    start_txn(32'h4000_0000, 4'hF, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("unsel_low", ctl_bits() | addressDataOut, 32'd0);
      step();
    end
    start_txn(32'h5000_1000, 4'hF, 8'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("unsel_high", ctl_bits() | addressDataOut, 32'd0);
      step();
    end

    // Excess write words are dropped; word 23 keeps its value.
    write_words(32'h5000_005C, 4'hF, 0, 1, 32'h7777_7777, 1'b0);
    write_words(32'h5000_0040, 4'hF, 6, 8, 32'hB0, 1'b0);
    read_words(32'h5000_0040, 7, 1'b0);

    // Abort an 8-word read during its third word.
    start_txn(32'h5000_0040, 4'hF, 8'd7, 1'b1);
    k = 0;
    while (!dataValidOut && k < 20) begin k++; step(); end
    for (int i = 0; i < 3; i++) begin
      check("abort_rd_data", addressDataOut, 32'hB0 + 32'(i));
      if (i < 2) step();
    end
    busErrorIn = 1'b1;
    step();
    busErrorIn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("abort_quiet", ctl_bits() | addressDataOut, 32'd0);
      step();
    end
    read_words(32'h5000_0010, 3, 1'b1);
    check("after_abort", last_rd0, 32'hA0);

    // Reset after 2 of 4 write words.
    write_words(32'h5000_0080, 4'hF, 3, 4, 32'hC0, 1'b0);
    start_txn(32'h5000_0080, 4'hF, 8'd3, 1'b0);
    k = 0;
    while (busyOut && k < 20) begin k++; step(); end
    dataValidIn = 1'b1; addressDataIn = 32'hD0; step();
    addressDataIn = 32'hD1; step();
    addressDataIn = 32'hD2; reset = 1'b0;
    #1;
    check("rst_wr_out", ctl_bits() | addressDataOut, 32'd0);
    step();
    dataValidIn = 1'b0; addressDataIn = '0; reset = 1'b1;
    exp_mem[32] = 32'hD0; exp_mem[33] = 32'hD1;
    read_words(32'h5000_0080, 3, 1'b0);
    check("rst_word34", exp_mem[34] ^ 32'hC2, 32'd0);

    // Reset while read data is on the bus.
    start_txn(32'h5000_0010, 4'hF, 8'd3, 1'b1);
    k = 0;
    while (!dataValidOut && k < 20) begin k++; step(); end
    check("rst_rd_active", {31'd0, dataValidOut}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_rd_out", ctl_bits() | addressDataOut, 32'd0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("rst_rd_discard", ctl_bits() | addressDataOut, 32'd0);
      step();
    end
    read_words(32'h5000_0010, 3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
